// File: rtl/mem_sched.sv
// Request scheduler: two 1-entry client buffers (icache, LSB), round-robin grant,
// single outstanding transaction at the byte-serial memory controller, fetch flush.
module mem_sched #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ack,
  output logic              ic_done,
  input  logic              ic_flush,
  input  logic              ls_req,
  input  logic              ls_wr,
  input  logic [2:0]        ls_width,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic              ls_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mc_req,
  output logic              mc_wr,
  output logic [2:0]        mc_width,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [DATA_W-1:0] mc_wdata,
  input  logic              mc_accept,
  input  logic              mc_done,
  input  logic [DATA_W-1:0] mc_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_e;

  state_e              state_q, state_d;
  logic                own_ic_q, own_ic_d;
  logic                last_ic_q, last_ic_d;
  logic                drop_q, drop_d;
  logic                ic_vld_q, ic_vld_d;
  logic [ADDR_W-1:0]   ic_baddr_q, ic_baddr_d;
  logic                ls_vld_q, ls_vld_d;
  logic                ls_bwr_q, ls_bwr_d;
  logic [2:0]          ls_bwidth_q, ls_bwidth_d;
  logic [ADDR_W-1:0]   ls_baddr_q, ls_baddr_d;
  logic [DATA_W-1:0]   ls_bwdata_q, ls_bwdata_d;
  logic                ic_ack_q, ic_ack_d;
  logic                ls_ack_q, ls_ack_d;
  logic                ic_done_q, ic_done_d;
  logic                ls_done_q, ls_done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mc_req_q, mc_req_d;
  logic                mc_wr_q, mc_wr_d;
  logic [2:0]          mc_width_q, mc_width_d;
  logic [ADDR_W-1:0]   mc_addr_q, mc_addr_d;
  logic [DATA_W-1:0]   mc_wdata_q, mc_wdata_d;

  logic free_ic, free_ls, ic_elig, grant_ic;

  always_comb begin
    state_d     = state_q;
    own_ic_d    = own_ic_q;
    last_ic_d   = last_ic_q;
    drop_d      = drop_q;
    ic_vld_d    = ic_vld_q;
    ic_baddr_d  = ic_baddr_q;
    ls_vld_d    = ls_vld_q;
    ls_bwr_d    = ls_bwr_q;
    ls_bwidth_d = ls_bwidth_q;
    ls_baddr_d  = ls_baddr_q;
    ls_bwdata_d = ls_bwdata_q;
    ic_ack_d    = 1'b0;
    ls_ack_d    = 1'b0;
    ic_done_d   = 1'b0;
    ls_done_d   = 1'b0;
    rdata_d     = rdata_q;
    mc_req_d    = mc_req_q;
    mc_wr_d     = mc_wr_q;
    mc_width_d  = mc_width_q;
    mc_addr_d   = mc_addr_q;
    mc_wdata_d  = mc_wdata_q;
    free_ic     = 1'b0;
    free_ls     = 1'b0;
    // A fetch being flushed this cycle must not be granted.
    ic_elig     = ic_vld_q && !ic_flush;
    grant_ic    = ic_elig && (!ls_vld_q || !last_ic_q);

    case (state_q)
      S_IDLE: begin
        if (ic_elig || ls_vld_q) begin
          mc_req_d  = 1'b1;
          own_ic_d  = grant_ic;
          last_ic_d = grant_ic;
          state_d   = S_ISSUE;
          if (grant_ic) begin
            mc_wr_d    = 1'b0;
            mc_width_d = 3'd4;
            mc_addr_d  = ic_baddr_q;
          end else begin
            mc_wr_d    = ls_bwr_q;
            mc_width_d = ls_bwidth_q;
            mc_addr_d  = ls_baddr_q;
            mc_wdata_d = ls_bwdata_q;
          end
        end
      end
      S_ISSUE: begin
        if (own_ic_q && ic_flush) begin
          mc_req_d = 1'b0;
          if (mc_accept) begin
            drop_d  = 1'b1;
            state_d = S_BUSY;
          end else begin
            state_d = S_IDLE;
          end
        end else if (mc_accept) begin
          mc_req_d = 1'b0;
          free_ic  = own_ic_q;
          free_ls  = !own_ic_q;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        if (own_ic_q && ic_flush) drop_d = 1'b1;
        if (mc_done) begin
          rdata_d = mc_rdata;
          if (own_ic_q) ic_done_d = !(drop_q || ic_flush);
          else          ls_done_d = 1'b1;
          drop_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ic_flush) begin
      ic_vld_d = 1'b0;
    end else begin
      if (free_ic) ic_vld_d = 1'b0;
      if ((!ic_vld_q || free_ic) && ic_req) begin
        ic_vld_d   = 1'b1;
        ic_baddr_d = ic_addr;
        ic_ack_d   = 1'b1;
      end
    end

    if (free_ls) ls_vld_d = 1'b0;
    if ((!ls_vld_q || free_ls) && ls_req) begin
      ls_vld_d    = 1'b1;
      ls_bwr_d    = ls_wr;
      ls_bwidth_d = ls_width;
      ls_baddr_d  = ls_addr;
      ls_bwdata_d = ls_wdata;
      ls_ack_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      own_ic_q    <= 1'b0;
      last_ic_q   <= 1'b1;
      drop_q      <= 1'b0;
      ic_vld_q    <= 1'b0;
      ic_baddr_q  <= '0;
      ls_vld_q    <= 1'b0;
      ls_bwr_q    <= 1'b0;
      ls_bwidth_q <= '0;
      ls_baddr_q  <= '0;
      ls_bwdata_q <= '0;
      ic_ack_q    <= 1'b0;
      ls_ack_q    <= 1'b0;
      ic_done_q   <= 1'b0;
      ls_done_q   <= 1'b0;
      rdata_q     <= '0;
      mc_req_q    <= 1'b0;
      mc_wr_q     <= 1'b0;
      mc_width_q  <= '0;
      mc_addr_q   <= '0;
      mc_wdata_q  <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      own_ic_q    <= own_ic_d;
      last_ic_q   <= last_ic_d;
      drop_q      <= drop_d;
      ic_vld_q    <= ic_vld_d;
      ic_baddr_q  <= ic_baddr_d;
      ls_vld_q    <= ls_vld_d;
      ls_bwr_q    <= ls_bwr_d;
      ls_bwidth_q <= ls_bwidth_d;
      ls_baddr_q  <= ls_baddr_d;
      ls_bwdata_q <= ls_bwdata_d;
      ic_ack_q    <= ic_ack_d;
      ls_ack_q    <= ls_ack_d;
      ic_done_q   <= ic_done_d;
      ls_done_q   <= ls_done_d;
      rdata_q     <= rdata_d;
      mc_req_q    <= mc_req_d;
      mc_wr_q     <= mc_wr_d;
      mc_width_q  <= mc_width_d;
      mc_addr_q   <= mc_addr_d;
      mc_wdata_q  <= mc_wdata_d;
    end
  end

  assign ic_ack   = ic_ack_q;
  assign ls_ack   = ls_ack_q;
  assign ic_done  = ic_done_q;
  assign ls_done  = ls_done_q;
  assign rdata    = rdata_q;
  assign mc_req   = mc_req_q;
  assign mc_wr    = mc_wr_q;
  assign mc_width = mc_width_q;
  assign mc_addr  = mc_addr_q;
  assign mc_wdata = mc_wdata_q;

endmodule
